// File: rtl/oam_dbuf_if.sv
// OAM double-buffer bus bundle.
// Carries the CPU shadow-RAM port, the renderer active-RAM read port and the
// copy control/status lines. clk and rst are kept as plain module ports.
//   master : drives cpu_ce/cpu_we/cpu_a/cpu_din, vsync, copy_req, ren_a
//   slave  : drives cpu_dout, ren_dout, busy, done
interface oam_dbuf_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 8
) ();
    logic          cpu_ce;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          vsync;
    logic          copy_req;
    logic [AW-1:0] ren_a;
    logic [DW-1:0] ren_dout;
    logic          busy;
    logic          done;

    modport master (
        output cpu_ce, cpu_we, cpu_a, cpu_din, vsync, copy_req, ren_a,
        input  cpu_dout, ren_dout, busy, done
    );

    modport slave (
        input  cpu_ce, cpu_we, cpu_a, cpu_din, vsync, copy_req, ren_a,
        output cpu_dout, ren_dout, busy, done
    );
endinterface

// File: rtl/oam_dbuf.sv
// OAM double buffer: the CPU owns a shadow RAM, the renderer reads an active
// RAM, and a copy engine moves shadow to active BPC entries per clock.
// Ports:
//   clk      : single clock, posedge
//   rst      : synchronous active-high reset (RAM contents are kept)
//   bus      : oam_dbuf_if.slave (CPU port, renderer port, vsync/copy_req,
//              busy/done status)
// Parameters: AW address width, DW data width, MODE (0 = vsync rising edge
// or copy_req triggers, 1 = copy_req only), BPC entries per clock (1/2/4).
module oam_dbuf #(
    parameter int unsigned AW   = 9,
    parameter int unsigned DW   = 8,
    parameter int unsigned MODE = 0,
    parameter int unsigned BPC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    oam_dbuf_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned BL    = $clog2(BPC);
    localparam int unsigned GW    = AW - BL;
    localparam int unsigned NGRP  = DEPTH / BPC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] active [DEPTH];
    logic [DW-1:0] rd_buf [BPC];

    logic [GW-1:0] rd_grp;
    logic [GW-1:0] wr_grp;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
    logic          wr_en;

    logic          vs_q;
    logic          pending;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] cpu_dout_q;
    logic [DW-1:0] ren_dout_q;

    logic          vs_rise_c;
    logic          trig_c;
    logic          last_grp_c;
    logic          copy_rd_c;
    logic          busy_nx;
    logic          done_nx;
    logic          pend_nx;

    // Trigger: copy_req in any mode, or a vsync rising edge in MODE 0.
    // Both in the same cycle collapse into one trigger.
    assign vs_rise_c  = (MODE == 0) && bus.vsync && !vs_q;
    assign trig_c     = bus.copy_req || vs_rise_c;
    assign last_grp_c = (rd_grp == GW'(NGRP - 1));

    assign rd_base = AW'(rd_grp) << BL;
    assign wr_base = AW'(wr_grp) << BL;

    // State register plus the registered status/control that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pending <= 1'b0;
            vs_q    <= 1'b1;
            rd_grp  <= '0;
            wr_grp  <= '0;
            wr_en   <= 1'b0;
        end else begin
            state   <= state_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            pending <= pend_nx;
            vs_q    <= bus.vsync;
            wr_en   <= copy_rd_c;
            wr_grp  <= rd_grp;
            if (copy_rd_c) begin
                rd_grp <= last_grp_c ? '0 : rd_grp + GW'(1);
            end
        end
    end

    // Next-state logic; FLUSH chains straight into COPY when a copy is queued.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trig_c) state_nx = COPY;
            COPY:    if (last_grp_c) state_nx = FLUSH;
            FLUSH:   state_nx = (trig_c || pending) ? COPY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; busy/done are registered from the next state so they
    // line up with the cycle the FSM is actually in.
    always_comb begin
        copy_rd_c = 1'b0;
        busy_nx   = 1'b0;
        done_nx   = 1'b0;
        pend_nx   = pending;
        if (state == COPY) begin
            copy_rd_c = 1'b1;
        end
        if (state_nx != IDLE) begin
            busy_nx = 1'b1;
        end
        if (state_nx == FLUSH) begin
            done_nx = 1'b1;
        end
        // A trigger in FLUSH is consumed directly by the FLUSH->COPY hop.
        if (state == COPY && trig_c) begin
            pend_nx = 1'b1;
        end else if (state == FLUSH) begin
            pend_nx = 1'b0;
        end
    end

    // Copy datapath: read a group from shadow, write it to active next cycle.
    // Same-edge CPU writes and renderer reads see the pre-edge RAM contents.
    always_ff @(posedge clk) begin
        if (copy_rd_c) begin
            for (int unsigned j = 0; j < BPC; j++) begin
                rd_buf[j] <= shadow[rd_base | AW'(j)];
            end
        end
        if (wr_en && !rst) begin
            for (int unsigned j = 0; j < BPC; j++) begin
                active[wr_base | AW'(j)] <= rd_buf[j];
            end
        end
    end

    // CPU shadow port: never stalls, one access per strobe.
    always_ff @(posedge clk) begin
        if (!rst && bus.cpu_ce && bus.cpu_we) begin
            shadow[bus.cpu_a] <= bus.cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_dout_q <= '0;
        end else if (bus.cpu_ce && !bus.cpu_we) begin
            cpu_dout_q <= shadow[bus.cpu_a];
        end
    end

    // Renderer port: registered read every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ren_dout_q <= '0;
        end else begin
            ren_dout_q <= active[bus.ren_a];
        end
    end

    assign bus.cpu_dout = cpu_dout_q;
    assign bus.ren_dout = ren_dout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_oam_dbuf.sv
// Bench for oam_dbuf: a MODE0/BPC1 instance checked every cycle against an
// entry-level model, and a MODE1/BPC4 instance checked with literal values.
module tb_oam_dbuf;

    localparam int N = 512;

    bit clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dbuf_if #(.AW(9), .DW(8)) b0 ();
    oam_dbuf_if #(.AW(9), .DW(8)) b1 ();

    oam_dbuf #(.AW(9), .DW(8), .MODE(0), .BPC(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    oam_dbuf #(.AW(9), .DW(8), .MODE(1), .BPC(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_vec = 0;
    int n_err = 0;

    // Model of instance 0: RAM images with known-bits, copy progress counter.
    logic [7:0] sh [N];
    logic [7:0] ac [N];
    bit         sv [N];
    bit         av [N];
    int         cyc = -1;       // copy cycle index of the coming cycle, -1 idle
    bit         pend = 0;
    bit         m_vs = 1;
    logic [7:0] snap;
    bit         snap_v;
    bit         chk_en = 0;
    bit         e_busy, e_done, e_cpu_v, e_ren_v;
    logic [7:0] e_cpu, e_ren;

    // Status monitors.
    int run0 = 0, last0 = 0, done0 = 0;
    int run1 = 0, last1 = 0, done1 = 0, busy1_tot = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_eval();
        bit trig;
        if (rst) begin
            cyc = -1; pend = 0; m_vs = 1;
            e_busy = 0; e_done = 0;
            e_cpu = 8'h00; e_cpu_v = 1;
            e_ren = 8'h00; e_ren_v = 1;
        end else begin
            e_ren = ac[b0.ren_a];
            e_ren_v = av[b0.ren_a];
            if (cyc >= 1) begin
                ac[cyc-1] = snap;
                av[cyc-1] = snap_v;
            end
            if (cyc >= 0 && cyc < N) begin
                snap = sh[cyc];
                snap_v = sv[cyc];
            end
            if (b0.cpu_ce) begin
                if (b0.cpu_we) begin
                    sh[b0.cpu_a] = b0.cpu_din;
                    sv[b0.cpu_a] = 1;
                end else begin
                    e_cpu = sh[b0.cpu_a];
                    e_cpu_v = sv[b0.cpu_a];
                end
            end
            trig = b0.copy_req || (b0.vsync && !m_vs);
            if (cyc < 0) begin
                if (trig) cyc = 0;
            end else if (cyc < N) begin
                cyc++;
                if (trig) pend = 1;
            end else begin
                cyc = (trig || pend) ? 0 : -1;
                pend = 0;
            end
            m_vs = b0.vsync;
            e_busy = (cyc >= 0);
            e_done = (cyc == N);
        end
        chk_en = 1;
    endtask

    task automatic tick();
        b1.vsync = b0.vsync;
        model_eval();
        @(negedge clk);
        #1;
    endtask

    task automatic idle0();
        b0.cpu_ce = 0; b0.cpu_we = 0; b0.copy_req = 0;
    endtask

    task automatic peek0(input string nm, input int a, input logic [7:0] exp);
        idle0();
        b0.ren_a = 9'(a);
        tick();
        check(nm, 32'(b0.ren_dout), 32'(exp));
    endtask

    task automatic peek1(input string nm, input int a, input logic [7:0] exp);
        b1.ren_a = 9'(a);
        tick();
        check(nm, 32'(b1.ren_dout), 32'(exp));
    endtask

    task automatic fill0(input logic [7:0] key);
        for (int i = 0; i < N; i++) begin
            b0.cpu_ce = 1; b0.cpu_we = 1;
            b0.cpu_a = 9'(i); b0.cpu_din = 8'(i) ^ key;
            tick();
        end
        idle0();
    endtask

    // One compare process: every cycle against the model, plus monitors.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", 32'(b0.busy), 32'(e_busy));
                check("done", 32'(b0.done), 32'(e_done));
                if (e_cpu_v) check("cpu_dout", 32'(b0.cpu_dout), 32'(e_cpu));
                if (e_ren_v) check("ren_dout", 32'(b0.ren_dout), 32'(e_ren));
            end
            if (b0.busy) run0++;
            else begin
                if (run0 != 0) last0 = run0;
                run0 = 0;
            end
            if (b0.done) done0++;
            if (b1.busy) begin
                run1++;
                busy1_tot++;
            end else begin
                if (run1 != 0) last1 = run1;
                run1 = 0;
            end
            if (b1.done) done1++;
        end
    end

    initial begin
        rst = 1;
        idle0();
        b0.cpu_a = '0; b0.cpu_din = '0; b0.ren_a = '0; b0.vsync = 1;
        b1.cpu_ce = 0; b1.cpu_we = 0; b1.cpu_a = '0; b1.cpu_din = '0;
        b1.copy_req = 0; b1.ren_a = '0; b1.vsync = 1;

        // Reset, then release with vsync already high: no false edge.
        repeat (4) tick();
        check("rst_busy", 32'(b0.busy), 32'h0);
        check("rst_done", 32'(b0.done), 32'h0);
        check("rst_cpu_dout", 32'(b0.cpu_dout), 32'h0);
        check("rst_ren_dout", 32'(b0.ren_dout), 32'h0);
        rst = 0;
        repeat (3) tick();
        check("no_false_edge", 32'(b0.busy), 32'h0);
        b0.vsync = 0;
        tick();

        // Fill both shadows; instance 1 gets its own pattern.
        for (int i = 0; i < N; i++) begin
            b0.cpu_ce = 1; b0.cpu_we = 1; b0.cpu_a = 9'(i); b0.cpu_din = 8'(i) ^ 8'h5A;
            b1.cpu_ce = 1; b1.cpu_we = 1; b1.cpu_a = 9'(i); b1.cpu_din = 8'(i) ^ 8'h3C;
            tick();
        end
        idle0();
        b1.cpu_ce = 0; b1.cpu_we = 0;

        // Full copy on vsync rising edge.
        done0 = 0;
        b0.vsync = 1;
        tick();
        b0.vsync = 0;
        repeat (530) tick();
        check("copy1_busy_len", 32'(last0), 32'd513);
        check("copy1_done_cnt", 32'(done0), 32'd1);
        check("model_ac3", 32'(ac[3]), 32'h59);
        peek0("act3", 3, 8'h59);
        peek0("act511", 511, 8'hA5);
        peek0("act200", 200, 8'h92);

        // Writes mid-copy: entry 0 already read, entry 511 not yet.
        done0 = 0;
        b0.vsync = 1;
        tick();
        b0.vsync = 0;
        repeat (100) tick();
        b0.cpu_ce = 1; b0.cpu_we = 1; b0.cpu_a = 9'd0; b0.cpu_din = 8'h11;
        tick();
        b0.cpu_a = 9'd511; b0.cpu_din = 8'h22;
        tick();
        idle0();
        repeat (430) tick();
        check("copy2_done_cnt", 32'(done0), 32'd1);
        peek0("act0_old", 0, 8'h5A);
        peek0("act511_new", 511, 8'h22);

        // copy_req during a copy queues a back-to-back second copy.
        done0 = 0;
        b0.vsync = 1;
        tick();
        b0.vsync = 0;
        repeat (10) tick();
        b0.copy_req = 1;
        tick();
        b0.copy_req = 0;
        repeat (1040) tick();
        check("chain_busy_len", 32'(last0), 32'd1026);
        check("chain_done_cnt", 32'(done0), 32'd2);
        check("model_ac0", 32'(ac[0]), 32'h11);
        peek0("act0_next", 0, 8'h11);

        // Reset in copy cycle 200 aborts the copy.
        fill0(8'hC3);
        done0 = 0;
        b0.vsync = 1;
        tick();
        b0.vsync = 0;
        repeat (200) tick();
        rst = 1;
        tick();
        rst = 0;
        check("abort_busy", 32'(b0.busy), 32'h0);
        repeat (3) tick();
        check("abort_no_done", 32'(done0), 32'd0);
        peek0("abort_act0", 0, 8'hC3);
        peek0("abort_act198", 198, 8'h05);
        peek0("abort_act199", 199, 8'h9D);
        peek0("abort_act511", 511, 8'h22);
        b0.vsync = 1;
        tick();
        b0.vsync = 0;
        repeat (530) tick();
        peek0("recopy_act199", 199, 8'h04);
        peek0("recopy_act511", 511, 8'h3C);

        // Randomized frames: CPU traffic, renderer sweep, vsync, copy_req.
        for (int f = 0; f < 6; f++) begin
            int len;
            len = int'($urandom_range(1100, 600));
            for (int c = 0; c < len; c++) begin
                b0.vsync = (c < 20);
                b0.cpu_ce = ($urandom_range(2, 0) != 0);
                b0.cpu_we = 1'($urandom);
                b0.cpu_a = 9'($urandom);
                b0.cpu_din = 8'($urandom);
                b0.copy_req = ($urandom_range(399, 0) == 0);
                b0.ren_a = b0.ren_a + 9'd1;
                tick();
            end
        end
        idle0();
        b0.vsync = 0;

        // Instance 1 (MODE 1, BPC 4): vsync alone never copies.
        check("mode1_vsync_ignored", 32'(busy1_tot), 32'd0);
        done1 = 0;
        b1.copy_req = 1;
        tick();
        b1.copy_req = 0;
        repeat (140) tick();
        check("bpc4_busy_len", 32'(last1), 32'd129);
        check("bpc4_done_cnt", 32'(done1), 32'd1);
        peek1("bpc4_act5", 5, 8'h39);
        peek1("bpc4_act6", 6, 8'h3A);
        peek1("bpc4_act256", 256, 8'h3C);
        peek1("bpc4_act511", 511, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
